controle_andares: RTL and testbench

Elevator floor controller that consumes the 16 latched call states and drives the matching per-floor clear lines back into the button-state block. It holds the current floor and chooses the travel direction with a collective (SCAN) policy. It times travel and door-open intervals and clears each call when the car opens its door at that floor. It sits between the button-state latches and the motor/door/display outputs.

---
 rtl/controle_andares.sv | 222 ++++++++++++++++++++++
 tb/tb_controle_andares.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_andares.sv
// controle_andares: SCAN elevator controller driving per-floor clears back to the call latches.
// clock/reset_n, estadobotao[15:0] in; cl[15:0], andar_atual[3:0], sobe, desce, porta_aberta out.
// Optional parking toward floor 0 when idle: define ESTACIONAMENTO_EN.
module controle_andares #(
  parameter int TEMPO_ANDAR  = 8,
  parameter int TEMPO_PORTA  = 4,
  parameter int TEMPO_OCIOSO = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] estadobotao,
  output logic [15:0] cl,
  output logic [3:0]  andar_atual,
  output logic        sobe,
  output logic        desce,
  output logic        porta_aberta
);

  typedef enum logic [1:0] {
    PARADO,
    MOVENDO,
    PORTA_ABERTA
  } estado_t;

  localparam logic [7:0] ULT_ANDAR = 8'(TEMPO_ANDAR - 1);
  localparam logic [7:0] ULT_PORTA = 8'(TEMPO_PORTA - 1);

  if (TEMPO_ANDAR < 1 || TEMPO_ANDAR > 255) begin : g_err_andar
    $error("TEMPO_ANDAR out of range");
  end
  if (TEMPO_PORTA < 1 || TEMPO_PORTA > 255) begin : g_err_porta
    $error("TEMPO_PORTA out of range");
  end
  if (TEMPO_OCIOSO < 1 || TEMPO_OCIOSO > 255) begin : g_err_ocioso
    $error("TEMPO_OCIOSO out of range");
  end

  estado_t     estado, estado_n;
  logic [3:0]  andar_n;
  logic        dir, dir_n;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] cl_n;
  logic        sobe_n, desce_n, porta_n;

  logic        acima, abaixo, aqui;
  logic [3:0]  prox;
  logic        n_aqui, n_acima, n_abaixo;

  assign acima  = |(estadobotao & (16'hFFFE << andar_atual));
  assign abaixo = |(estadobotao & ~(16'hFFFF << andar_atual));
  assign aqui   = estadobotao[andar_atual];

  // Floor the car reaches at the end of the current travel interval,
  // saturated so the position can never wrap.
  always_comb begin
    prox = andar_atual;
    if (sobe && andar_atual != 4'd15)
      prox = andar_atual + 4'd1;
    else if (desce && andar_atual != 4'd0)
      prox = andar_atual - 4'd1;
  end

  assign n_aqui   = estadobotao[prox];
  assign n_acima  = |(estadobotao & (16'hFFFE << prox));
  assign n_abaixo = |(estadobotao & ~(16'hFFFF << prox));

`ifdef ESTACIONAMENTO_EN
  localparam logic [7:0] ULT_OCIOSO = 8'(TEMPO_OCIOSO - 1);

  logic [7:0] ocioso;
  logic       ocioso_ok, ocioso_fim;
  logic       estac, estac_n;

  assign ocioso_ok  = (estado == PARADO) &&
                      (estadobotao == '0) &&
                      (andar_atual != 4'd0);
  assign ocioso_fim = ocioso_ok && (ocioso == ULT_OCIOSO);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ocioso <= '0;
      estac  <= 1'b0;
    end else begin
      ocioso <= (ocioso_ok && !ocioso_fim) ? ocioso + 8'd1 : '0;
      estac  <= estac_n;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado       <= PARADO;
      andar_atual  <= '0;
      dir          <= 1'b1;
      cnt          <= '0;
      cl           <= '0;
      sobe         <= 1'b0;
      desce        <= 1'b0;
      porta_aberta <= 1'b0;
    end else begin
      estado       <= estado_n;
      andar_atual  <= andar_n;
      dir          <= dir_n;
      cnt          <= cnt_n;
      cl           <= cl_n;
      sobe         <= sobe_n;
      desce        <= desce_n;
      porta_aberta <= porta_n;
    end
  end

  always_comb begin
    estado_n = estado;
    andar_n  = andar_atual;
    dir_n    = dir;
    cnt_n    = cnt;
    cl_n     = cl;
    sobe_n   = sobe;
    desce_n  = desce;
    porta_n  = porta_aberta;
`ifdef ESTACIONAMENTO_EN
    estac_n  = estac;
`endif

    unique case (estado)
      PARADO: begin
        cnt_n   = '0;
        cl_n    = '0;
        sobe_n  = 1'b0;
        desce_n = 1'b0;
        porta_n = 1'b0;
`ifdef ESTACIONAMENTO_EN
        estac_n = 1'b0;
`endif
        if (aqui) begin
          estado_n = PORTA_ABERTA;
          porta_n  = 1'b1;
          cl_n     = 16'(1) << andar_atual;
        end else if (dir && acima) begin
          estado_n = MOVENDO;
          sobe_n   = 1'b1;
        end else if (abaixo) begin
          estado_n = MOVENDO;
          desce_n  = 1'b1;
          dir_n    = 1'b0;
        end else if (acima) begin
          estado_n = MOVENDO;
          sobe_n   = 1'b1;
          dir_n    = 1'b1;
        end
`ifdef ESTACIONAMENTO_EN
        else if (ocioso_fim) begin
          estado_n = MOVENDO;
          desce_n  = 1'b1;
          dir_n    = 1'b0;
          estac_n  = 1'b1;
        end
`endif
      end

      MOVENDO: begin
`ifdef ESTACIONAMENTO_EN
        // A real call cancels parking; SCAN takes over at the next floor.
        if (estadobotao != '0)
          estac_n = 1'b0;
`endif
        if (cnt == ULT_ANDAR) begin
          andar_n = prox;
          cnt_n   = '0;
          if (n_aqui) begin
            estado_n = PORTA_ABERTA;
            sobe_n   = 1'b0;
            desce_n  = 1'b0;
            porta_n  = 1'b1;
            cl_n     = 16'(1) << prox;
`ifdef ESTACIONAMENTO_EN
            estac_n  = 1'b0;
`endif
          end else if ((sobe && n_acima) ||
                       (desce && n_abaixo)) begin
            estado_n = MOVENDO;
          end
`ifdef ESTACIONAMENTO_EN
          else if (estac &&
                   estadobotao == '0 &&
                   prox != 4'd0) begin
            estado_n = MOVENDO;
          end
`endif
          else begin
            estado_n = PARADO;
            sobe_n   = 1'b0;
            desce_n  = 1'b0;
`ifdef ESTACIONAMENTO_EN
            estac_n  = 1'b0;
`endif
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end

      PORTA_ABERTA: begin
        // cl stays high the whole interval so repeated presses
        // at this floor are swallowed by the latch.
        if (cnt == ULT_PORTA) begin
          estado_n = PARADO;
          cnt_n    = '0;
          porta_n  = 1'b0;
          cl_n     = '0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end

      default: begin
        estado_n = PARADO;
      end
    endcase
  end

endmodule

// File: tb/tb_controle_andares.sv
// tb_controle_andares: directed bench for the SCAN floor controller.
// Models the button latches: a press pulse sets a bit, cl clears it.
module tb_controle_andares;

  logic        clock;
  logic        reset_n;
  logic [15:0] estadobotao;
  logic [15:0] cl;
  logic [3:0]  andar_atual;
  logic        sobe, desce, porta_aberta;

  logic [15:0] press;
  logic [15:0] latched;

  int checks;
  int errors;

  controle_andares dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .estadobotao (estadobotao),
    .cl          (cl),
    .andar_atual (andar_atual),
    .sobe        (sobe),
    .desce       (desce),
    .porta_aberta(porta_aberta)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) latched <= '0;
    else          latched <= (latched & ~cl) | press;
  end
  assign estadobotao = latched;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_press(input logic [15:0] m);
    press = m;
    tick();
    press = '0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    press   = '0;
    tick();
    tick();
    checks++;
    if ({cl, andar_atual, sobe, desce, porta_aberta} !== 23'd0) begin
      errors++;
      $display("FAIL reset_hold got cl=%h andar=%0d s=%b d=%b p=%b want 0",
               cl, andar_atual, sobe, desce, porta_aberta);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({cl, andar_atual, sobe, desce, porta_aberta} !== 23'd0) begin
      errors++;
      $display("FAIL reset_idle got cl=%h andar=%0d s=%b d=%b p=%b want 0",
               cl, andar_atual, sobe, desce, porta_aberta);
    end
  endtask

  task automatic test_door_here;
    do_press(16'h0001);
    checks++;
    if (porta_aberta !== 1'b0) begin
      errors++;
      $display("FAIL door0_decide got p=%b want 0", porta_aberta);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({porta_aberta, cl, andar_atual, sobe, desce} !==
          {1'b1, 16'h0001, 4'd0, 2'b00}) begin
        errors++;
        $display("FAIL door0_open[%0d] got p=%b cl=%h andar=%0d want p=1 cl=0001 andar=0",
                 i, porta_aberta, cl, andar_atual);
      end
    end
    tick();
    checks++;
    if ({porta_aberta, cl, sobe, desce, andar_atual} !== 23'd0) begin
      errors++;
      $display("FAIL door0_close got p=%b cl=%h andar=%0d want p=0 cl=0 andar=0",
               porta_aberta, cl, andar_atual);
    end
  endtask

  task automatic test_travel_up;
    do_press(16'h0008);
    for (int k = 1; k <= 24; k++) begin
      tick();
      checks++;
      if ({sobe, desce, porta_aberta, cl, andar_atual} !==
          {1'b1, 1'b0, 1'b0, 16'h0, 4'((k - 1) / 8)}) begin
        errors++;
        $display("FAIL travel_up[%0d] got s=%b d=%b p=%b andar=%0d want s=1 andar=%0d",
                 k, sobe, desce, porta_aberta, andar_atual, (k - 1) / 8);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({sobe, porta_aberta, cl, andar_atual} !==
          {1'b0, 1'b1, 16'h0008, 4'd3}) begin
        errors++;
        $display("FAIL arrive3[%0d] got s=%b p=%b cl=%h andar=%0d want s=0 p=1 cl=0008 andar=3",
                 i, sobe, porta_aberta, cl, andar_atual);
      end
    end
    tick();
    checks++;
    if ({porta_aberta, cl, sobe, desce} !== 19'd0) begin
      errors++;
      $display("FAIL arrive3_close got p=%b cl=%h want 0", porta_aberta, cl);
    end
  endtask

  task automatic test_scan_reverse;
    int n;
    do_press(16'h0080);
    n = 0;
    while (andar_atual !== 4'd5 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (andar_atual !== 4'd5) begin
      errors++;
      $display("FAIL scan_reach5 got andar=%0d want 5", andar_atual);
    end
    do_press(16'h0004);
    n = 0;
    while (porta_aberta !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if ({porta_aberta, cl, andar_atual, desce} !==
        {1'b1, 16'h0080, 4'd7, 1'b0}) begin
      errors++;
      $display("FAIL scan_serve7 got p=%b cl=%h andar=%0d d=%b want p=1 cl=0080 andar=7",
               porta_aberta, cl, andar_atual, desce);
    end
    n = 0;
    while (porta_aberta === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL scan_door7_len got %0d want 4", n);
    end
    checks++;
    if ({sobe, desce, porta_aberta, cl} !== 19'd0) begin
      errors++;
      $display("FAIL scan_idle_cycle got s=%b d=%b p=%b cl=%h want 0",
               sobe, desce, porta_aberta, cl);
    end
    tick();
    checks++;
    if ({desce, sobe, andar_atual} !== {2'b10, 4'd7}) begin
      errors++;
      $display("FAIL scan_reverse got d=%b s=%b andar=%0d want d=1 s=0 andar=7",
               desce, sobe, andar_atual);
    end
    n = 0;
    while (desce === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 40) begin
      errors++;
      $display("FAIL scan_down_len got %0d want 40", n);
    end
    checks++;
    if ({porta_aberta, cl, andar_atual} !== {1'b1, 16'h0004, 4'd2}) begin
      errors++;
      $display("FAIL scan_serve2 got p=%b cl=%h andar=%0d want p=1 cl=0004 andar=2",
               porta_aberta, cl, andar_atual);
    end
    n = 0;
    while (porta_aberta === 1'b1 && n < 10) begin
      tick();
      n++;
    end
  endtask

  task automatic test_top_floor;
    int n;
    do_press(16'h8000);
    n = 0;
    while (porta_aberta !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if ({porta_aberta, cl, andar_atual} !== {1'b1, 16'h8000, 4'd15}) begin
      errors++;
      $display("FAIL top_arrive got p=%b cl=%h andar=%0d want p=1 cl=8000 andar=15",
               porta_aberta, cl, andar_atual);
    end
    n = 0;
    while (porta_aberta === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    do_press(16'h8000);
    tick();
    checks++;
    if ({porta_aberta, cl, andar_atual} !== {1'b1, 16'h8000, 4'd15}) begin
      errors++;
      $display("FAIL top_reopen got p=%b cl=%h andar=%0d want p=1 cl=8000 andar=15",
               porta_aberta, cl, andar_atual);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({sobe, andar_atual} !== {1'b0, 4'd15}) begin
        errors++;
        $display("FAIL top_no_up[%0d] got s=%b andar=%0d want s=0 andar=15",
                 i, sobe, andar_atual);
      end
    end
  endtask

  task automatic test_reset_mid_travel;
    int n;
    do_press(16'h0001);
    n = 0;
    while (andar_atual !== 4'd6 && n < 200) begin
      tick();
      n++;
    end
    tick();
    tick();
    tick();
    checks++;
    if ({desce, andar_atual} !== {1'b1, 4'd6}) begin
      errors++;
      $display("FAIL midtravel_pre got d=%b andar=%0d want d=1 andar=6",
               desce, andar_atual);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cl, andar_atual, sobe, desce, porta_aberta} !== 23'd0) begin
      errors++;
      $display("FAIL async_reset got cl=%h andar=%0d s=%b d=%b p=%b want 0",
               cl, andar_atual, sobe, desce, porta_aberta);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({cl, andar_atual, sobe, desce, porta_aberta} !== 23'd0) begin
      errors++;
      $display("FAIL post_reset got cl=%h andar=%0d s=%b d=%b p=%b want 0",
               cl, andar_atual, sobe, desce, porta_aberta);
    end
  endtask

  task automatic test_parking;
    int n;
    do_press(16'h0010);
    n = 0;
    while (porta_aberta !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if ({porta_aberta, andar_atual} !== {1'b1, 4'd4}) begin
      errors++;
      $display("FAIL park_arrive4 got p=%b andar=%0d want p=1 andar=4",
               porta_aberta, andar_atual);
    end
    n = 0;
    while (porta_aberta === 1'b1 && n < 10) begin
      tick();
      n++;
    end
`ifdef ESTACIONAMENTO_EN
    for (int i = 1; i <= 31; i++) begin
      tick();
      checks++;
      if ({desce, sobe, andar_atual} !== {2'b00, 4'd4}) begin
        errors++;
        $display("FAIL park_wait[%0d] got d=%b andar=%0d want d=0 andar=4",
                 i, desce, andar_atual);
      end
    end
    tick();
    checks++;
    if ({desce, andar_atual} !== {1'b1, 4'd4}) begin
      errors++;
      $display("FAIL park_start got d=%b andar=%0d want d=1 andar=4",
               desce, andar_atual);
    end
    for (int j = 1; j <= 32; j++) begin
      tick();
      checks++;
      if (j == 32) begin
        if ({desce, porta_aberta, andar_atual} !== {2'b00, 4'd0}) begin
          errors++;
          $display("FAIL park_arrive0 got d=%b p=%b andar=%0d want d=0 p=0 andar=0",
                   desce, porta_aberta, andar_atual);
        end
      end else begin
        if ({desce, porta_aberta} !== 2'b10) begin
          errors++;
          $display("FAIL park_move[%0d] got d=%b p=%b want d=1 p=0",
                   j, desce, porta_aberta);
        end
      end
    end
    tick();
    tick();
    checks++;
    if ({porta_aberta, cl, andar_atual} !== 21'd0) begin
      errors++;
      $display("FAIL park_no_door got p=%b cl=%h andar=%0d want 0",
               porta_aberta, cl, andar_atual);
    end
`else
    for (int i = 1; i <= 80; i++) begin
      tick();
      checks++;
      if ({desce, sobe, porta_aberta, andar_atual} !== {3'b000, 4'd4}) begin
        errors++;
        $display("FAIL stay_put[%0d] got d=%b s=%b p=%b andar=%0d want 0 andar=4",
                 i, desce, sobe, porta_aberta, andar_atual);
      end
    end
`endif
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    press   = '0;
    reset_n = 1'b0;
    test_reset();
    test_door_here();
    test_travel_up();
    test_scan_reverse();
    test_top_floor();
    test_reset_mid_travel();
    test_parking();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
